ff_excitation_gen: RTL and testbench
====================================

Name: ff_excitation_gen

Overview:
- Inverse of the flip-flop conversion logic: takes a stream of desired next-state bits and produces the excitation inputs that drive a selected flip-flop type (SR, JK, D, T) to that state.
- Tracks the present state internally, so consecutive targets form a state sequence.
- Sits in front of the sequential-circuit flip-flop models as a stimulus source. Can also check a real flip-flop's output against the requested sequence.

Parameters:
- INIT_Q, 1'b0, reset value of the internal present-state model; must equal the driven flip-flop's initial q.
- DC_VAL, 1'b0, value substituted for every JK don't-care excitation (0 or 1).
- CNT_W, 8, width of the transfer and mismatch counters.

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  FF type: 0=SR, 1=JK, 2=D, 3=T; sampled only on target accept.
- tgt_valid  in  1  target bit valid.
- tgt_bit  in  1  desired next state Q+.
- tgt_ready  out  1  block can accept a target.
- exc_valid  out  1  excitation pair valid.
- exc_ready  in  1  consumer takes the excitation on this edge.
- exc_a  out  1  S / J / D / T input.
- exc_b  out  1  R / K input; 0 for D and T.
- exc_mode  out  2  mode latched with this excitation.
- q_model  out  1  present state after all accepted targets.
- xfer_cnt  out  CNT_W  completed excitation handshakes, saturating.
- q_fb  in  1  q of the driven flip-flop (used only with the checker).
- mismatch  out  1  sticky checker error flag.
- mis_cnt  out  CNT_W  checker mismatch count, saturating.

Behaviour:
- Reset (sync, rst=1 at posedge) clears all of the following, and wins over any simultaneous handshake:
  - exc_valid=0, exc_a=0, exc_b=0, exc_mode=0.
  - q_model=INIT_Q.
  - xfer_cnt=0, mis_cnt=0, mismatch=0.
  - Any pending excitation is dropped; no partial state survives.
- One-deep output register:
  - tgt_ready = !exc_valid | exc_ready (combinational).
  - Accept = tgt_valid & tgt_ready.
  - Latency: excitation valid in the cycle after accept.
- On accept:
  - Compute the excitation from (q_model, tgt_bit, mode).
  - Load exc_a, exc_b and exc_mode; set exc_valid=1; set q_model<=tgt_bit.
- Excitation rules, written as present q -> Q+ : exc_a exc_b:
  - SR: 0->0:00, 0->1:10, 1->0:01, 1->1:00. The SR forbidden pair 11 must never be emitted.
  - JK: 0->0:0,DC; 0->1:1,DC; 1->0:DC,1; 1->1:DC,0. DC means DC_VAL.
  - D: exc_a=tgt_bit, exc_b=0.
  - T: exc_a=q_model^tgt_bit, exc_b=0.
- Two-state FSM:
  - EMPTY: exc_valid=0. Accept -> FULL.
  - FULL: exc_valid=1.
    - exc_ready & accept -> stay FULL, new pair loaded.
    - exc_ready & !accept -> EMPTY, exc_valid=0, exc_a/exc_b hold their value.
    - !exc_ready -> hold all outputs stable.
- xfer_cnt increments on each exc_valid & exc_ready; saturates at all-ones.
- mode changes while FULL do not affect the held pair; each pair uses the mode latched at its accept.
- Mixed-mode sequences are legal. q_model is the shared state across modes.

Optional Feature:
- Macro FF_EXC_CHECK_EN.
- Defined:
  - On each exc handshake, register the expected state (the q_model value loaded at that pair's accept).
  - In the following cycle, compare it with q_fb.
  - On inequality: mismatch<=1 (sticky until rst) and mis_cnt increments (saturating).
  - A back-to-back handshake in the compare cycle overwrites the expected state only after that comparison.
- Undefined:
  - No compare logic.
  - mismatch=0 and mis_cnt=0 constantly; q_fb is ignored.

Decomposition:
- Package ff_exc_pkg holds:
  - Enum ff_mode_t {FF_SR, FF_JK, FF_D, FF_T}.
  - Typedef exc_pair_t {a,b}.
  - A pure function excite(q, qn, mode, dc) returning exc_pair_t.
- Sub-module ff_exc_checker holds the expected-state register and the comparator/counters. It is instantiated only under FF_EXC_CHECK_EN.

Test Plan:
- Reset INIT_Q=0, mode=SR, targets 1,1,0,0 with exc_ready=1 -> pairs 10,00,01,00; q_model 1,1,0,0; xfer_cnt=4.
- mode=JK, DC_VAL=0, from q=0, targets 1,0,0,1 -> pairs 10,01,00,10. Repeat with DC_VAL=1 -> 11,11,01,11.
- mode=T, targets 1,1,0,1 from q=0 -> exc_a 1,0,1,1, exc_b=0. mode=D, same targets -> exc_a 1,1,0,1.
- Hold exc_ready=0 for 3 cycles with tgt_valid=1 -> tgt_ready=0, outputs stable, q_model unchanged. Release -> next target accepted in the same cycle.
- rst asserted while FULL with tgt_valid=1 -> next cycle exc_valid=0, q_model=INIT_Q, counters 0, target not accepted.
- FF_EXC_CHECK_EN, drive an srff-to-jk flip-flop model from the exc outputs in JK mode -> mismatch stays 0. Force q_fb=~q for one cycle -> mismatch=1, mis_cnt=1, persists until rst.

Source files
------------

// File: rtl/ff_exc_pkg.sv
// ff_exc_pkg: flip-flop type encoding, excitation pair type and the excitation table.
package ff_exc_pkg;
  typedef enum logic [1:0] {FF_SR, FF_JK, FF_D, FF_T} ff_mode_t;
  typedef struct packed {
    logic a;
    logic b;
  } exc_pair_t;
  function automatic exc_pair_t excite(input logic q, input logic qn, input ff_mode_t mode, input logic dc);
    exc_pair_t p;
    p.a = 1'b0;
    p.b = 1'b0;
    case (mode)
      FF_SR: begin
        p.a = !q && qn;
        p.b = q && !qn;
      end
      FF_JK: begin
        p.a = q ? dc : qn;
        p.b = q ? !qn : dc;
      end
      FF_D: p.a = qn;
      default: p.a = q ^ qn;
    endcase
    return p;
  endfunction
endpackage

// File: rtl/ff_exc_checker.sv
// ff_exc_checker: compares the driven flip-flop's q one cycle after each handshake against the expected state.
module ff_exc_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hs,
  input  logic             i_exp,
  input  logic             i_q_fb,
  output logic             o_mismatch,
  output logic [CNT_W-1:0] o_mis_cnt
);
  logic r_exp, r_pend, r_mis;
  logic [CNT_W-1:0] r_cnt;
  logic w_err;
  assign w_err = r_pend && (r_exp != i_q_fb);
  assign o_mismatch = r_mis;
  assign o_mis_cnt = r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp <= 1'b0;
      r_pend <= 1'b0;
      r_mis <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_pend <= i_hs;
      if (i_hs) r_exp <= i_exp;
      if (w_err) r_mis <= 1'b1;
      if (w_err && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ff_excitation_gen.sv
// ff_excitation_gen: turns a stream of target states into SR/JK/D/T excitation pairs.
// Define FF_EXC_CHECK_EN to build the q_fb checker; otherwise mismatch/mis_cnt are tied to 0.
module ff_excitation_gen
  import ff_exc_pkg::*;
#(
  parameter logic INIT_Q = 1'b0,
  parameter logic DC_VAL = 1'b0,
  parameter int   CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             exc_valid,
  input  logic             exc_ready,
  output logic             exc_a,
  output logic             exc_b,
  output logic [1:0]       exc_mode,
  output logic             q_model,
  output logic [CNT_W-1:0] xfer_cnt,
  input  logic             q_fb,
  output logic             mismatch,
  output logic [CNT_W-1:0] mis_cnt
);
  typedef enum logic {S_EMPTY, S_FULL} state_t;
  state_t r_state, w_next;
  logic r_a, r_b, r_q;
  logic [1:0] r_mode;
  logic [CNT_W-1:0] r_xfer;
  logic w_acc, w_hs;
  exc_pair_t w_pair;
  assign exc_valid = r_state == S_FULL;
  assign tgt_ready = !exc_valid || exc_ready;
  assign w_acc = tgt_valid && tgt_ready;
  assign w_hs = exc_valid && exc_ready;
  assign w_pair = excite(r_q, tgt_bit, ff_mode_t'(mode), DC_VAL);
  assign exc_a = r_a;
  assign exc_b = r_b;
  assign exc_mode = r_mode;
  assign q_model = r_q;
  assign xfer_cnt = r_xfer;
  always_comb begin
    w_next = r_state;
    w_next = w_acc ? S_FULL : (w_hs ? S_EMPTY : r_state);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_a <= 1'b0;
      r_b <= 1'b0;
      r_mode <= 2'd0;
      r_q <= INIT_Q;
      r_xfer <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_a <= w_pair.a;
        r_b <= w_pair.b;
        r_mode <= mode;
        r_q <= tgt_bit;
      end
      if (w_hs && !(&r_xfer)) r_xfer <= r_xfer + 1'b1;
    end
  end
`ifdef FF_EXC_CHECK_EN
  // r_q still holds the handshaken pair's target: any new accept lands on the same edge.
  ff_exc_checker #(.CNT_W(CNT_W)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .i_hs      (w_hs),
    .i_exp     (r_q),
    .i_q_fb    (q_fb),
    .o_mismatch(mismatch),
    .o_mis_cnt (mis_cnt)
  );
`else
  logic w_unused;
  assign w_unused = q_fb;
  assign mismatch = 1'b0;
  assign mis_cnt = '0;
`endif
endmodule

// File: tb/tb_ff_excitation_gen.sv
// tb_ff_excitation_gen: scoreboard bench driving a DC_VAL=0 and a DC_VAL=1/CNT_W=2 instance in lockstep.
module tb_ff_excitation_gen;
`ifdef FF_EXC_CHECK_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  typedef struct packed {
    logic a0, b0, a1, b1;
    logic [1:0] m;
    logic q;
  } ent_t;
  logic clk = 1'b0, rst = 1'b1, tgt_valid = 1'b0, tgt_bit = 1'b0, exc_ready = 1'b1;
  logic inv = 1'b0, fq, q_fb;
  logic [1:0] mode = 2'd0;
  logic tgt_ready, exc_valid0, exc_a0, exc_b0, q_model0, mismatch0;
  logic [1:0] exc_mode0;
  logic [7:0] xfer0, mis_cnt0;
  logic tgt_ready1, exc_valid1, exc_a1, exc_b1, q_model1, mismatch1;
  logic [1:0] exc_mode1, xfer1, mis_cnt1;
  int n_chk = 0, n_fail = 0;
  ent_t sb[$];
  always #5 clk = ~clk;
  ff_excitation_gen u_dut0 (
    .clk(clk), .rst(rst), .mode(mode), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(tgt_ready), .exc_valid(exc_valid0), .exc_ready(exc_ready), .exc_a(exc_a0),
    .exc_b(exc_b0), .exc_mode(exc_mode0), .q_model(q_model0), .xfer_cnt(xfer0),
    .q_fb(q_fb), .mismatch(mismatch0), .mis_cnt(mis_cnt0)
  );
  ff_excitation_gen #(.DC_VAL(1'b1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .mode(mode), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
    .tgt_ready(tgt_ready1), .exc_valid(exc_valid1), .exc_ready(exc_ready), .exc_a(exc_a1),
    .exc_b(exc_b1), .exc_mode(exc_mode1), .q_model(q_model1), .xfer_cnt(xfer1),
    .q_fb(q_fb), .mismatch(mismatch1), .mis_cnt(mis_cnt1)
  );
  // reference flip-flop clocked by dut0's handshakes
  always @(posedge clk)
    if (rst) fq <= 1'b0;
    else if (exc_valid0 && exc_ready)
      case (exc_mode0)
        2'd0: fq <= exc_a0 ? 1'b1 : (exc_b0 ? 1'b0 : fq);
        2'd1: fq <= (exc_a0 && exc_b0) ? ~fq : (exc_a0 ? 1'b1 : (exc_b0 ? 1'b0 : fq));
        2'd2: fq <= exc_a0;
        default: fq <= fq ^ exc_a0;
      endcase
  assign q_fb = fq ^ inv;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst && exc_valid0 && exc_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 16'd1, 16'd0);
      else begin
        ent_t e;
        e = sb.pop_front();
        chk("pair0", 16'({exc_a0, exc_b0, exc_mode0, q_model0}), 16'({e.a0, e.b0, e.m, e.q}));
        chk("pair1", 16'({exc_a1, exc_b1, exc_mode1, q_model1}), 16'({e.a1, e.b1, e.m, e.q}));
      end
    end
  end
  task automatic send(input logic [1:0] m, input logic t, input logic [3:0] ab);
    @(negedge clk);
    mode = m;
    tgt_bit = t;
    tgt_valid = 1'b1;
    #1;
    for (int k = 0; k < 20 && !tgt_ready; k++) begin
      @(negedge clk);
      #1;
    end
    if (!tgt_ready) chk("accept_timeout", 16'd0, 16'd1);
    else sb.push_back(ent_t'{ab[3], ab[2], ab[1], ab[0], m, t});
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic chk_reset(input string name);
    chk({name, "_valid"}, 16'({exc_valid0, exc_valid1}), 16'd0);
    chk({name, "_pair"}, 16'({exc_a0, exc_b0, exc_mode0, exc_a1, exc_b1, exc_mode1}), 16'd0);
    chk({name, "_q"}, 16'({q_model0, q_model1}), 16'd0);
    chk({name, "_xfer"}, 16'({xfer0, xfer1}), 16'd0);
    chk({name, "_ready"}, 16'({tgt_ready, tgt_ready1}), 16'b11);
    chk({name, "_mis"}, 16'({mismatch0, mis_cnt0, mismatch1, mis_cnt1}), 16'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset("reset");
    send(2'd0, 1'b1, 4'b1010);
    send(2'd0, 1'b1, 4'b0000);
    send(2'd0, 1'b0, 4'b0101);
    send(2'd0, 1'b0, 4'b0000);
    idle(2);
    chk("xfer_sr", 16'(xfer0), 16'd4);
    chk("xfer_sat", 16'(xfer1), 16'd3);
    send(2'd1, 1'b1, 4'b1011);
    send(2'd1, 1'b0, 4'b0111);
    send(2'd1, 1'b0, 4'b0001);
    send(2'd1, 1'b1, 4'b1011);
    send(2'd2, 1'b0, 4'b0000);
    send(2'd3, 1'b1, 4'b1010);
    send(2'd3, 1'b1, 4'b0000);
    send(2'd3, 1'b0, 4'b1010);
    send(2'd3, 1'b1, 4'b1010);
    send(2'd2, 1'b1, 4'b1010);
    send(2'd2, 1'b1, 4'b1010);
    send(2'd2, 1'b0, 4'b0000);
    send(2'd2, 1'b1, 4'b1010);
    idle(2);
    chk("xfer_mixed", 16'(xfer0), 16'd17);
    exc_ready = 1'b0;
    send(2'd0, 1'b0, 4'b0101);
    @(negedge clk);
    mode = 2'd3;
    tgt_bit = 1'b1;
    tgt_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_ready", 16'(tgt_ready), 16'd0);
      chk("hold_out", 16'({exc_valid0, exc_a0, exc_b0, exc_mode0, q_model0}), 16'b101000);
      @(negedge clk);
      #1;
    end
    exc_ready = 1'b1;
    #1;
    chk("release_ready", 16'(tgt_ready), 16'd1);
    sb.push_back(ent_t'{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1});
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    idle(2);
    chk("xfer_hold", 16'(xfer0), 16'd19);
    exc_ready = 1'b0;
    send(2'd0, 1'b0, 4'b0101);
    @(negedge clk);
    tgt_bit = 1'b1;
    tgt_valid = 1'b1;
    exc_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tgt_valid = 1'b0;
    sb.delete();
    idle(1);
    chk_reset("rst_full");
    send(2'd0, 1'b1, 4'b1010);
    idle(2);
    chk("xfer_after_rst", 16'(xfer0), 16'd1);
    send(2'd1, 1'b0, 4'b0111);
    send(2'd1, 1'b1, 4'b1011);
    idle(3);
    chk("mis_clean", 16'({mismatch0, mis_cnt0}), 16'd0);
    inv = 1'b1;
    send(2'd1, 1'b0, 4'b0111);
    idle(3);
    inv = 1'b0;
    idle(1);
    chk("mis_flag0", 16'({mismatch0, mis_cnt0}), 16'(CK * 257));
    chk("mis_flag1", 16'({mismatch1, mis_cnt1}), 16'(CK * 5));
    send(2'd1, 1'b0, 4'b0001);
    idle(3);
    chk("mis_sticky", 16'({mismatch0, mis_cnt0}), 16'(CK * 257));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    chk_reset("rst_end");
    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
